// File: rtl/cu_pkg.sv
// Shared types for the multicycle control unit: state and opcode encodings, ALU add constant.
package cu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM_RD = 3'd3,
        MEM_WR = 3'd4,
        WB     = 3'd5,
        BRANCH = 3'd6,
        TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        OP_ALU_R = 3'd0,
        OP_ALU_I = 3'd1,
        OP_LOAD  = 3'd2,
        OP_STORE = 3'd3,
        OP_BEQ   = 3'd4,
        OP_B     = 3'd5
    } opcode_t;

    localparam int ALU_ADD = 0;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle; master = control unit, slave = datapath and memory.
// The trap output exists only when CU_ILLEGAL_TRAP_EN is defined.
interface multicycle_control_unit_if #(
    parameter int INSTR_W = 16,
    parameter int FUNCT_W = 2,
    parameter int CNT_W   = 16
);
    logic [INSTR_W-1:0] instr;
    logic               eq_flag;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               pc_write;
    logic               pc_src;
    logic               reg_write;
    logic               mem_to_reg;
    logic [1:0]         reg_src;
    logic               alu_src_b;
    logic [FUNCT_W-1:0] alu_ctrl;
    logic               busy;
    logic [2:0]         state_o;
    logic [CNT_W-1:0]   instr_retired;
`ifdef CU_ILLEGAL_TRAP_EN
    logic               trap;

    modport master (
        input  instr, eq_flag, mem_ready,
        output mem_req, mem_read, mem_write, ir_write, pc_write, pc_src, reg_write,
               mem_to_reg, reg_src, alu_src_b, alu_ctrl, busy, state_o, instr_retired, trap
    );
    modport slave (
        output instr, eq_flag, mem_ready,
        input  mem_req, mem_read, mem_write, ir_write, pc_write, pc_src, reg_write,
               mem_to_reg, reg_src, alu_src_b, alu_ctrl, busy, state_o, instr_retired, trap
    );
`else
    modport master (
        input  instr, eq_flag, mem_ready,
        output mem_req, mem_read, mem_write, ir_write, pc_write, pc_src, reg_write,
               mem_to_reg, reg_src, alu_src_b, alu_ctrl, busy, state_o, instr_retired
    );
    modport slave (
        output instr, eq_flag, mem_ready,
        input  mem_req, mem_read, mem_write, ir_write, pc_write, pc_src, reg_write,
               mem_to_reg, reg_src, alu_src_b, alu_ctrl, busy, state_o, instr_retired
    );
`endif
endinterface

// File: rtl/cu_op_decode.sv
// Combinational opcode classifier; anything outside the six defined opcodes is illegal.
module cu_op_decode
    import cu_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic [OP_W-1:0] op,
    output logic            is_alu_r,
    output logic            is_alu_i,
    output logic            is_load,
    output logic            is_store,
    output logic            is_beq,
    output logic            is_b,
    output logic            is_illegal
);
    assign is_alu_r   = (op == OP_W'(OP_ALU_R));
    assign is_alu_i   = (op == OP_W'(OP_ALU_I));
    assign is_load    = (op == OP_W'(OP_LOAD));
    assign is_store   = (op == OP_W'(OP_STORE));
    assign is_beq     = (op == OP_W'(OP_BEQ));
    assign is_b       = (op == OP_W'(OP_B));
    assign is_illegal = ~(is_alu_r | is_alu_i | is_load | is_store | is_beq | is_b);
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath enables and a retire counter.
// Optional CU_ILLEGAL_TRAP_EN: illegal opcodes lock the unit in TRAP until reset.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OP_W    = 3,
    parameter int FUNCT_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);
    state_t             state;
    logic [OP_W-1:0]    op_q;
    logic [FUNCT_W-1:0] funct_q;
    logic [CNT_W-1:0]   retired;
    logic [OP_W-1:0]    op_in;
    logic [OP_W-1:0]    op_sel;
    logic               is_alu_r, is_alu_i, is_load, is_store, is_beq, is_b, is_illegal;
    logic               retire;
    logic               unused_instr_bits;

    assign op_in             = bus.instr[INSTR_W-1 -: OP_W];
    assign unused_instr_bits = ^bus.instr;

    // DECODE steers on the live IR (the latch is loaded on that same edge); later states use the latch.
    assign op_sel = (state == DECODE) ? op_in : op_q;

    cu_op_decode #(.OP_W(OP_W)) u_op_decode (
        .op         (op_sel),
        .is_alu_r   (is_alu_r),
        .is_alu_i   (is_alu_i),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_beq     (is_beq),
        .is_b       (is_b),
        .is_illegal (is_illegal)
    );

    always_comb begin
        retire = 1'b0;
        case (state)
`ifndef CU_ILLEGAL_TRAP_EN
            DECODE:     retire = is_illegal;
`endif
            MEM_WR:     retire = bus.mem_ready;
            WB, BRANCH: retire = 1'b1;
            default:    retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            op_q    <= '0;
            funct_q <= '0;
            retired <= '0;
        end else begin
            if (retire) retired <= retired + 1'b1;
            case (state)
                FETCH:  if (bus.mem_ready) state <= DECODE;
                DECODE: begin
                    op_q    <= op_in;
                    funct_q <= bus.instr[FUNCT_W-1:0];
                    if (is_alu_r | is_alu_i | is_load | is_store) state <= EXEC;
                    else if (is_beq | is_b)                       state <= BRANCH;
`ifdef CU_ILLEGAL_TRAP_EN
                    else                                          state <= TRAP;
`else
                    else                                          state <= FETCH;
`endif
                end
                EXEC: begin
                    if (is_load)       state <= MEM_RD;
                    else if (is_store) state <= MEM_WR;
                    else               state <= WB;
                end
                MEM_RD:     if (bus.mem_ready) state <= WB;
                MEM_WR:     if (bus.mem_ready) state <= FETCH;
                WB, BRANCH: state <= FETCH;
                TRAP:       state <= TRAP;
                default:    state <= FETCH;
            endcase
        end
    end

    // Outputs are forced low throughout reset, even though the state register already reads FETCH.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_src    = 2'b00;
        bus.alu_src_b  = 1'b0;
        bus.alu_ctrl   = '0;
        bus.busy       = 1'b0;
        bus.state_o    = 3'd0;
`ifdef CU_ILLEGAL_TRAP_EN
        bus.trap       = 1'b0;
`endif
        if (!reset) begin
            bus.busy    = (state != FETCH);
            bus.state_o = state;
            case (state)
                FETCH: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_read = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                end
                EXEC: begin
                    bus.alu_src_b  = ~is_alu_r;
                    bus.alu_ctrl   = is_alu_r ? funct_q : FUNCT_W'(ALU_ADD);
                    bus.reg_src[1] = is_store;
                end
                MEM_RD: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_read = 1'b1;
                end
                MEM_WR: begin
                    bus.mem_req    = 1'b1;
                    bus.mem_write  = 1'b1;
                    bus.reg_src[1] = 1'b1;
                end
                WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = is_load;
                end
                BRANCH: begin
                    bus.pc_src     = 1'b1;
                    bus.pc_write   = is_b | bus.eq_flag;
                    bus.reg_src[0] = is_beq;
                end
`ifdef CU_ILLEGAL_TRAP_EN
                TRAP:    bus.trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.instr_retired = retired;

endmodule
